// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: FSM encoding, default
// geometry/timing, and the address legality check.
package data_mem_responder_pkg;

  localparam int DEPTH_LOG2_DEF  = 6;
  localparam int WAIT_CYCLES_DEF = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Misaligned, or any bit set above the word-index field.
  function automatic logic addr_err(input logic [31:0] addr, input int depth_log2);
    logic [31:0] hi_mask;
    hi_mask = ~((32'd1 << (depth_log2 + 2)) - 32'd1);
    return (addr[1:0] != 2'b00) || ((addr & hi_mask) != 32'd0);
  endfunction

endpackage

// File: rtl/be_ram.sv
// Word-wide storage with byte-enabled synchronous write and a registered read
// port that holds its last value while no read is issued.
module be_ram #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            be_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with programmable wait states in
// front of a byte-enabled memory.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam logic [3:0] CNT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        write_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  logic        hs, access;
  logic        acc_write, acc_err;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_be;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;

  assign req_ready = (state_q == ST_IDLE) && reset;
  assign hs        = req_valid && req_ready;

  // A zero-wait access happens on the handshake edge itself, so it must take
  // the request straight from the inputs rather than the capture registers.
  assign acc_write = (state_q == ST_IDLE) ? req_write : write_q;
  assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign acc_be    = (state_q == ST_IDLE) ? req_be    : be_q;
  assign acc_err   = addr_err(acc_addr, DEPTH_LOG2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'd0;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          access  = 1'b1;
          state_d = ST_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign err_d = access ? acc_err : err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Reset gates the write so an in-flight store is abandoned cleanly.
  assign ram_we = access && acc_write && !acc_err && reset;
  assign ram_re = access && !acc_write && !acc_err;

  be_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (acc_addr[DEPTH_LOG2+1:2]),
    .wdata_i(acc_wdata),
    .be_i   (acc_be),
    .rdata_o(ram_rdata)
  );

  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !write_q && !err_q) ? ram_rdata : 32'd0;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder with two wait-state
// settings, checked against a word-array reference model.
module tb_data_mem_responder;

  localparam int  DL2 = 6;
  localparam int  NW  = 1 << DL2;
  localparam time PER = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        r2_ready, r2_valid, r2_err, r2_busy;
  logic [31:0] r2_rdata;
  logic        r0_ready, r0_valid, r0_err, r0_busy;
  logic [31:0] r0_rdata;
  logic        v2, v0;

  logic        o_ready, o_valid, o_err, o_busy;
  logic [31:0] o_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] m2 [NW];
  logic [31:0] m0 [NW];

  always #(PER/2) clk = ~clk;

  assign v2 = req_valid & ~sel;
  assign v0 = req_valid & sel;

  assign o_ready = sel ? r0_ready : r2_ready;
  assign o_valid = sel ? r0_valid : r2_valid;
  assign o_err   = sel ? r0_err   : r2_err;
  assign o_busy  = sel ? r0_busy  : r2_busy;
  assign o_rdata = sel ? r0_rdata : r2_rdata;

  data_mem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(v2), .req_ready(r2_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(r2_valid), .resp_ready(resp_ready), .resp_rdata(r2_rdata),
    .resp_err(r2_err), .busy(r2_busy)
  );

  data_mem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(r0_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(r0_valid), .resp_ready(resp_ready), .resp_rdata(r0_rdata),
    .resp_err(r0_err), .busy(r0_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a word array; illegal addresses touch nothing and read as 0.
  task automatic model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] exp_rdata, output logic exp_err);
    int unsigned idx;
    logic [31:0] word;
    exp_err   = (addr % 4 != 0) || (addr >= 4 * NW);
    exp_rdata = 32'd0;
    if (!exp_err) begin
      idx  = addr / 4;
      word = sel ? m0[idx] : m2[idx];
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
        if (sel) m0[idx] = word; else m2[idx] = word;
      end else begin
        exp_rdata = word;
      end
    end
  endtask

  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold, output time hs_t);
    int          guard, lat;
    logic [31:0] exp_rdata, got_rdata;
    logic        exp_err, got_err;
    hs_t  = 0;
    guard = 0;
    while (!o_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!o_ready) begin
      chk("ready_timeout", 32'(o_ready), 32'd1);
      return;
    end
    model(wr, addr, wdata, be, exp_rdata, exp_err);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk);
    hs_t = $time;
    #1;
    req_valid = 1'b0;
    req_write = ~wr; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    // Edges counted from and including the handshake edge.
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), sel ? 32'd1 : 32'd3);
    if (!o_valid) return;
    got_rdata = o_rdata;
    got_err   = o_err;
    chk("rdata", got_rdata, exp_rdata);
    chk("err", 32'(got_err), 32'(exp_err));
    if (hold > 0) resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_write = $urandom_range(0, 1); req_addr = $urandom & 32'hFC;
      @(posedge clk); #1;
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_rdata", o_rdata, got_rdata);
      chk("hold_err", 32'(o_err), 32'(got_err));
      chk("hold_req_ready", 32'(o_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_valid", 32'(o_valid), 32'd0);
    chk("done_req_ready", 32'(o_ready), 32'd1);
  endtask

  task automatic rand_addr(output logic [31:0] a);
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       a = {24'd0, 6'($urandom_range(0, NW - 1)), 2'b00};
    else if (r == 7) a = {24'd0, 6'($urandom), 2'($urandom_range(1, 3))};
    else             a = $urandom | (32'd1 << $urandom_range(8, 31));
  endtask

  initial begin
    time         t, t_prev;
    logic [31:0] a, junk;
    logic        je;

    sel = 1'b0; reset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0; resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(r2_valid), 32'd0);
    chk("rst_rdata", r2_rdata, 32'd0);
    chk("rst_err", 32'(r2_err), 32'd0);
    chk("rst_busy", 32'(r2_busy), 32'd0);
    chk("rst_busy0", 32'(r0_busy), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_req_ready", 32'(r2_ready), 32'd1);
    chk("rel_req_ready0", 32'(r0_ready), 32'd1);

    // Give every word a known value so later loads are defined.
    for (int i = 0; i < NW; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, t);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, t);
    txn(1'b0, 32'h10, 32'd0, 4'h0, 0, t);
    chk("deadbeef_model", m2[4], 32'hDEADBEEF);
    txn(1'b1, 32'h10, 32'h00000055, 4'h1, 0, t);
    chk("partial_model", m2[4], 32'hDEADBE55);
    txn(1'b0, 32'h10, 32'd0, 4'h3, 0, t);
    txn(1'b0, 32'h12, 32'd0, 4'hF, 0, t);
    txn(1'b0, 32'h100, 32'd0, 4'hF, 0, t);
    txn(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 0, t);
    txn(1'b0, 32'h10, 32'd0, 4'hF, 0, t);
    txn(1'b0, 32'h10, 32'd0, 4'hF, 5, t);
    txn(1'b1, 32'h18, 32'hA5A5A5A5, 4'h0, 2, t);
    txn(1'b0, 32'h18, 32'd0, 4'hF, 0, t);

    // Reset while a store to 0x20 waits: the store must never land.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
    req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_busy", 32'(r2_busy), 32'd1);
    reset = 1'b0;
    #2;
    chk("wrst_valid", 32'(r2_valid), 32'd0);
    chk("wrst_rdata", r2_rdata, 32'd0);
    chk("wrst_err", 32'(r2_err), 32'd0);
    chk("wrst_busy", 32'(r2_busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("wrst_req_ready", 32'(r2_ready), 32'd1);
    txn(1'b0, 32'h20, 32'd0, 4'hF, 0, t);

    // Reset while a completed store's response is pending: the store stays.
    model(1'b1, 32'h24, 32'hCAFEF00D, 4'hF, junk, je);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h24;
    req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rresp_valid", 32'(r2_valid), 32'd1);
    reset = 1'b0;
    #2;
    chk("rresp_rst_valid", 32'(r2_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 32'h24, 32'd0, 4'hF, 0, t);

    for (int i = 0; i < 150; i++) begin
      rand_addr(a);
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 2), t);
    end

    sel = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NW; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, t);
    txn(1'b1, 32'h30, 32'h0BADC0DE, 4'hC, 0, t);
    txn(1'b0, 32'h30, 32'd0, 4'hF, 0, t_prev);
    for (int i = 0; i < 6; i++) begin
      txn(1'b0, 32'($urandom_range(0, NW - 1) * 4), 32'd0, 4'hF, 0, t);
      chk("throughput", 32'(t - t_prev), 32'(2 * PER));
      t_prev = t;
    end
    for (int i = 0; i < 100; i++) begin
      rand_addr(a);
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 2), t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH_LOG2, default 6, sets the word count of the storage array (2**DEPTH_LOG2 words).
REQ-002 Parameter: WAIT_CYCLES, default 2, sets the wait states inserted between request acceptance and data access (legal range 0..15).
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  initiator presents a request.
REQ-006 req_ready  out  1  responder can accept a request this cycle.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data.
REQ-010 req_be  in  4  byte enables for stores; bit i enables bits [8i+7:8i].
REQ-011 resp_valid  out  1  response available.
REQ-012 resp_ready  in  1  initiator accepts the response.
REQ-013 resp_rdata  out  32  load data; 0 for stores and errors.
REQ-014 resp_err  out  1  request was misaligned or out of range.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid and req_ready are both high at a rising edge.
REQ-018 On handshake, the block SHALL capture write, addr, wdata, and be, then enter WAIT if WAIT_CYCLES>0, otherwise perform the access and enter RESP.
REQ-019 In WAIT, a 4-bit counter SHALL count WAIT_CYCLES edges; on the last edge the access SHALL be performed and the state SHALL become RESP.
REQ-020 Latency: resp_valid SHALL rise exactly WAIT_CYCLES+1 edges after the handshake edge.
REQ-021 Word index SHALL be addr[DEPTH_LOG2+1:2]; a store SHALL update only the enabled bytes; be=0 SHALL be a legal store that changes nothing.
REQ-022 A load SHALL return the full 32-bit word regardless of be.
REQ-023 Error: if addr[1:0]!=0 or any addr bit above DEPTH_LOG2+1 is set, the block SHALL suppress the store, return resp_rdata=0 and resp_err=1, and keep the same latency.
REQ-024 In RESP, resp_valid, resp_rdata, and resp_err SHALL be held stable until resp_ready is sampled high, and the state SHALL then return to IDLE.
REQ-025 No new request SHALL be accepted in the RESP cycle in which the response completes; req_ready SHALL rise the following cycle.
REQ-026 Changes on req_* inputs outside a handshake SHALL have no effect.
REQ-027 A load immediately following a store to the same word SHALL return the stored data.

Reset
REQ-028 While reset=0, the block SHALL force state=IDLE, counter=0, req_ready=1 (after release), resp_valid=0, resp_rdata=0, resp_err=0, and busy=0.
REQ-029 A reset during WAIT SHALL abandon the request, and no store SHALL be performed.
REQ-030 A reset during RESP SHALL discard the response, but a store already performed SHALL remain.
REQ-031 Storage contents SHALL NOT be reset.

Structure
REQ-032 The FSM state encoding and the default values of DEPTH_LOG2 and WAIT_CYCLES SHALL live in the shared CPU package.
REQ-033 The storage array SHALL be one sub-module, be_ram, with a synchronous byte-enabled write and a registered read.

Verification
REQ-034 WAIT_CYCLES=2: store addr=0x10, wdata=0xDEADBEEF, be=4'hF, then load 0x10 -> rdata=0xDEADBEEF, err=0, resp_valid 3 edges after each handshake.
REQ-035 Store 0x10, wdata=0x00000055, be=4'h1, over 0xDEADBEEF, then load 0x10 -> 0xDEADBE55.
REQ-036 Load addr=0x12 and load addr=0x100 -> err=1, rdata=0; a following load of 0x10 is unchanged.
REQ-037 resp_ready held low for 5 cycles -> resp_valid and rdata stable; req_ready stays 0 and req_valid is ignored.
REQ-038 Assert reset in WAIT of a store to 0x20 (wdata=0x12345678) -> outputs return to reset values; a later load of 0x20 returns the prior contents.
REQ-039 WAIT_CYCLES=0: back-to-back loads with resp_ready=1 -> resp_valid 1 edge after handshake; throughput is one request per 2 cycles.
